// File: rtl/dual_port_ram_pipelined.sv
// True dual-port RAM with independent per-port read/write latency pipelines.
// Define DPRAM_COLLISION_DETECT_EN to enable the o_wr_collision pulse.

module dpram_wr_pipe #(
  parameter int LAT = 2,
  parameter int AW  = 4,
  parameter int DW  = 16,
  parameter int BW  = DW/8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req,
  input  logic [BW-1:0] i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_din,
  output logic          o_vld,
  output logic [BW-1:0] o_be,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_din
);
  if (LAT == 1) begin : g_direct
    assign o_vld  = i_req;
    assign o_be   = i_be;
    assign o_addr = i_addr;
    assign o_din  = i_din;
  end else begin : g_pipe
    localparam int S = LAT - 1;
    logic [S:1]         r_vld;
    logic [S:1][BW-1:0] r_be;
    logic [S:1][AW-1:0] r_addr;
    logic [S:1][DW-1:0] r_din;
    logic [S:0]         w_vld;
    logic [S:0][BW-1:0] w_be;
    logic [S:0][AW-1:0] w_addr;
    logic [S:0][DW-1:0] w_din;

    // Index 0 is the incoming request; index S is the stage that commits.
    assign w_vld  = {r_vld, i_req};
    assign w_be   = {r_be, i_be};
    assign w_addr = {r_addr, i_addr};
    assign w_din  = {r_din, i_din};

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_vld  <= '0;
        r_be   <= '0;
        r_addr <= '0;
        r_din  <= '0;
      end else begin
        r_vld  <= w_vld[S-1:0];
        r_be   <= w_be[S-1:0];
        r_addr <= w_addr[S-1:0];
        r_din  <= w_din[S-1:0];
      end
    end

    assign o_vld  = w_vld[S];
    assign o_be   = w_be[S];
    assign o_addr = w_addr[S];
    assign o_din  = w_din[S];
  end
endmodule

module dpram_rd_pipe #(
  parameter int LAT = 2,
  parameter int DW  = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  output logic [DW-1:0] o_dat
);
  logic [LAT:1]         r_vld;
  logic [LAT:1][DW-1:0] r_dat;
  logic [LAT:0]         w_vld;
  logic [LAT:0][DW-1:0] w_dat;

  assign w_vld = {r_vld, i_req};
  assign w_dat = {r_dat, i_dat};

  // The last stage is the output register: it only loads on a valid beat so
  // o_dat holds the last returned word between pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
      r_dat <= '0;
    end else begin
      r_vld <= w_vld[LAT-1:0];
      for (int i = 1; i <= LAT; i++) begin
        if (i < LAT || w_vld[i-1]) r_dat[i] <= w_dat[i-1];
      end
    end
  end

  assign o_vld = w_vld[LAT];
  assign o_dat = w_dat[LAT];
endmodule

module dual_port_ram_pipelined #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 4,
  parameter int WRITE_LATENCY_A = 3,
  parameter int READ_LATENCY_A  = 2,
  parameter int WRITE_LATENCY_B = 2,
  parameter int READ_LATENCY_B  = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en_a,
  input  logic                    i_we_a,
  input  logic [DATA_WIDTH/8-1:0] i_be_a,
  input  logic [ADDR_WIDTH-1:0]   i_addr_a,
  input  logic [DATA_WIDTH-1:0]   i_din_a,
  output logic [DATA_WIDTH-1:0]   o_dout_a,
  output logic                    o_valid_a,
  input  logic                    i_en_b,
  input  logic                    i_we_b,
  input  logic [DATA_WIDTH/8-1:0] i_be_b,
  input  logic [ADDR_WIDTH-1:0]   i_addr_b,
  input  logic [DATA_WIDTH-1:0]   i_din_b,
  output logic [DATA_WIDTH-1:0]   o_dout_b,
  output logic                    o_valid_b,
  output logic                    o_wr_collision
);
  localparam int BW    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_cv_a, w_cv_b, w_commit_a, w_commit_b;
  logic [BW-1:0]         w_cbe_a, w_cbe_b;
  logic [ADDR_WIDTH-1:0] w_caddr_a, w_caddr_b;
  logic [DATA_WIDTH-1:0] w_cdin_a, w_cdin_b, w_rdat_a, w_rdat_b;

  dpram_wr_pipe #(.LAT(WRITE_LATENCY_A), .AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_wr_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_en_a & i_we_a), .i_be(i_be_a),
    .i_addr(i_addr_a), .i_din(i_din_a),
    .o_vld(w_cv_a), .o_be(w_cbe_a), .o_addr(w_caddr_a), .o_din(w_cdin_a));

  dpram_wr_pipe #(.LAT(WRITE_LATENCY_B), .AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_wr_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_en_b & i_we_b), .i_be(i_be_b),
    .i_addr(i_addr_b), .i_din(i_din_b),
    .o_vld(w_cv_b), .o_be(w_cbe_b), .o_addr(w_caddr_b), .o_din(w_cdin_b));

  // A reset edge suppresses any commit, including ones already in flight.
  assign w_commit_a = w_cv_a & ~i_rst;
  assign w_commit_b = w_cv_b & ~i_rst;

  // B's bytes are applied first so A's overlapping bytes take priority.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < BW; k++) begin
      if (w_commit_b && w_cbe_b[k]) r_mem[w_caddr_b][8*k +: 8] <= w_cdin_b[8*k +: 8];
      if (w_commit_a && w_cbe_a[k]) r_mem[w_caddr_a][8*k +: 8] <= w_cdin_a[8*k +: 8];
    end
  end

  assign w_rdat_a = r_mem[i_addr_a];
  assign w_rdat_b = r_mem[i_addr_b];

  dpram_rd_pipe #(.LAT(READ_LATENCY_A), .DW(DATA_WIDTH)) u_rd_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_en_a & ~i_we_a), .i_dat(w_rdat_a),
    .o_vld(o_valid_a), .o_dat(o_dout_a));

  dpram_rd_pipe #(.LAT(READ_LATENCY_B), .DW(DATA_WIDTH)) u_rd_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_en_b & ~i_we_b), .i_dat(w_rdat_b),
    .o_vld(o_valid_b), .o_dat(o_dout_b));

`ifdef DPRAM_COLLISION_DETECT_EN
  logic r_coll;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_coll <= 1'b0;
    else       r_coll <= w_commit_a & w_commit_b & (w_caddr_a == w_caddr_b) &
                         (|(w_cbe_a & w_cbe_b));
  end
  assign o_wr_collision = r_coll;
`else
  assign o_wr_collision = 1'b0;
`endif
endmodule

// File: tb/tb_dual_port_ram_pipelined.sv
// Directed bench for dual_port_ram_pipelined (default latencies A:W3/R2, B:W2/R3).
module tb_dual_port_ram_pipelined;
  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, we_a, en_b, we_b;
  logic [1:0]  be_a, be_b;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] din_a, din_b, dout_a, dout_b;
  logic        va, vb, coll;
  int          total = 0;
  int          bad   = 0;

  dual_port_ram_pipelined dut (
    .i_clk(clk), .i_rst(rst),
    .i_en_a(en_a), .i_we_a(we_a), .i_be_a(be_a), .i_addr_a(addr_a), .i_din_a(din_a),
    .o_dout_a(dout_a), .o_valid_a(va),
    .i_en_b(en_b), .i_we_b(we_b), .i_be_b(be_b), .i_addr_b(addr_b), .i_din_b(din_b),
    .o_dout_b(dout_b), .o_valid_b(vb),
    .o_wr_collision(coll));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 0; we_a = 0; be_a = 0; addr_a = 0; din_a = 0;
    en_b = 0; we_b = 0; be_b = 0; addr_b = 0; din_b = 0;
  endtask

  task automatic set_wa(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    en_a = 1; we_a = 1; addr_a = a; din_a = d; be_a = be;
  endtask

  task automatic set_wb(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    en_b = 1; we_b = 1; addr_b = a; din_b = d; be_b = be;
  endtask

  // Issue one read, wait a bounded number of cycles for the valid pulse.
  task automatic rd(input bit pb, input logic [3:0] a, input logic [15:0] exp,
                    input string tag);
    int n;
    if (pb) begin en_b = 1; we_b = 0; addr_b = a; end
    else    begin en_a = 1; we_a = 0; addr_a = a; end
    tick();
    idle();
    n = 0;
    while (!(pb ? vb : va) && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, {31'd0, pb ? vb : va}, 32'd1);
    chk(tag, {16'd0, pb ? dout_b : dout_a}, {16'd0, exp});
    tick();
  endtask

  initial begin
    logic [15:0] pre_d [8];
    logic [3:0]  pre_a [8];
    pre_a = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9, 4'd7, 4'd5, 4'd4};
    pre_d = '{16'h1111, 16'h2222, 16'h3333, 16'h0F0F, 16'h1234, 16'h0000,
              16'h5555, 16'h4444};

    rst = 1; idle();
    tick(); tick();
    chk("rst_dout_a", {16'd0, dout_a}, 32'd0);
    chk("rst_dout_b", {16'd0, dout_b}, 32'd0);
    chk("rst_valid", {30'd0, va, vb}, 32'd0);
    chk("rst_coll", {31'd0, coll}, 32'd0);
    rst = 0;

    for (int i = 0; i < 8; i++) begin
      set_wa(pre_a[i], pre_d[i], 2'b11);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) tick();

    // Back-to-back A reads, latency 2
    en_a = 1; we_a = 0; addr_a = 4'd0; tick();
    chk("b2b_v0", {31'd0, va}, 32'd0);
    addr_a = 4'd1; tick();
    chk("b2b_v1", {31'd0, va}, 32'd1);
    chk("b2b_d1", {16'd0, dout_a}, 32'h1111);
    addr_a = 4'd2; tick();
    chk("b2b_v2", {31'd0, va}, 32'd1);
    chk("b2b_d2", {16'd0, dout_a}, 32'h2222);
    idle(); tick();
    chk("b2b_v3", {31'd0, va}, 32'd1);
    chk("b2b_d3", {16'd0, dout_a}, 32'h3333);
    tick();
    chk("b2b_v4", {31'd0, va}, 32'd0);
    chk("hold_a", {16'd0, dout_a}, 32'h3333);

    // Read-first at commit edge, new data one edge later
    set_wa(4'd3, 16'hA5A5, 2'b11); tick();          // edge 0
    idle(); tick();                                  // edge 1
    en_b = 1; addr_b = 4'd3; tick();                 // edge 2 (commit)
    tick();                                          // edge 3
    chk("rf_v3", {31'd0, vb}, 32'd0);
    idle(); tick();                                  // edge 4
    chk("rf_old_v", {31'd0, vb}, 32'd1);
    chk("rf_old_d", {16'd0, dout_b}, 32'h0F0F);
    tick();                                          // edge 5
    chk("rf_new_v", {31'd0, vb}, 32'd1);
    chk("rf_new_d", {16'd0, dout_b}, 32'hA5A5);
    tick();
    chk("rf_v6", {31'd0, vb}, 32'd0);
    chk("hold_b", {16'd0, dout_b}, 32'hA5A5);

    // Same-address commit at the same edge, overlapping bytes: A wins byte 0
    set_wa(4'd7, 16'hAAAA, 2'b01); tick();
    idle(); set_wb(4'd7, 16'hBBBB, 2'b11); tick();
    idle(); tick();
`ifdef DPRAM_COLLISION_DETECT_EN
    chk("coll_pulse", {31'd0, coll}, 32'd1);
`else
    chk("coll_pulse", {31'd0, coll}, 32'd0);
`endif
    tick();
    chk("coll_clear", {31'd0, coll}, 32'd0);
    rd(1'b0, 4'd7, 16'hBBAA, "prio_a7");

    // Same address, disjoint bytes: merge, no collision
    set_wa(4'd4, 16'h00CC, 2'b01); tick();
    idle(); set_wb(4'd4, 16'hDD00, 2'b10); tick();
    idle(); tick();
    chk("nocoll", {31'd0, coll}, 32'd0);
    rd(1'b1, 4'd4, 16'hDDCC, "merge_a4");

    // Reset mid-flight kills write to 5 and a B read
    set_wa(4'd5, 16'hDEAD, 2'b11);
    en_b = 1; we_b = 0; addr_b = 4'd0; tick();      // edge 0
    rst = 1; idle(); tick();                         // edge 1
    chk("mrst_valid", {30'd0, va, vb}, 32'd0);
    chk("mrst_dout_a", {16'd0, dout_a}, 32'd0);
    chk("mrst_dout_b", {16'd0, dout_b}, 32'd0);
    rst = 0; tick();
    chk("mrst_vb_late", {31'd0, vb}, 32'd0);
    tick(); tick();
    chk("mrst_vb_late2", {31'd0, vb}, 32'd0);
    rd(1'b0, 4'd5, 16'h5555, "mrst_a5");

    // Zero byte enables commit nothing
    set_wa(4'd9, 16'hFFFF, 2'b00); tick();
    idle(); tick(); tick(); tick();
    chk("be0_coll", {31'd0, coll}, 32'd0);
    rd(1'b1, 4'd9, 16'h1234, "be0_a9");

    // Disabled port B write is ignored
    en_b = 0; we_b = 1; addr_b = 4'd2; din_b = 16'hBEEF; be_b = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("enb0_nov", {31'd0, vb}, 32'd0);
    end
    idle(); tick();
    rd(1'b1, 4'd2, 16'h3333, "enb0_a2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dual_port_ram_pipelined.md
DUAL_PORT_RAM_PIPELINED -- requirements
Module: dual_port_ram_pipelined

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter WRITE_LATENCY_A, 3, port A write-commit latency in cycles, >=1.
REQ-004 SHALL have parameter READ_LATENCY_A, 2, port A read-data latency in cycles, >=1.
REQ-005 SHALL have parameter WRITE_LATENCY_B, 2, port B write-commit latency in cycles, >=1.
REQ-006 SHALL have parameter READ_LATENCY_B, 3, port B read-data latency in cycles, >=1.
REQ-007 SHALL have port i_clk, input, 1, the single clock for both ports; all logic on its rising edge.
REQ-008 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-009 SHALL have ports i_en_a / i_en_b, input, 1 each, port request enable.
REQ-010 SHALL have ports i_we_a / i_we_b, input, 1 each, 1 = write, 0 = read (when enabled).
REQ-011 SHALL have ports i_be_a / i_be_b, input, DATA_WIDTH/8 each, byte write enables; bit k covers bits [8k+7:8k].
REQ-012 SHALL have ports i_addr_a / i_addr_b, input, ADDR_WIDTH each, word address.
REQ-013 SHALL have ports i_din_a / i_din_b, input, DATA_WIDTH each, write data.
REQ-014 SHALL have ports o_dout_a / o_dout_b, output, DATA_WIDTH each, read data.
REQ-015 SHALL have ports o_valid_a / o_valid_b, output, 1 each, one-cycle qualifier for o_dout_x.
REQ-016 SHALL have port o_wr_collision, output, 1, same-address write-commit collision pulse.

Function
REQ-017 SHALL sample a request on port X at the rising edge N where i_en_x=1; i_en_x=0 means no operation.
REQ-018 SHALL commit a write sampled at edge N into the array at edge N+WRITE_LATENCY_X-1, updating only bytes with i_be_x set; i_be_x=0 commits nothing.
REQ-019 SHALL pipeline addr, data and byte enables of each write independently per port, accepting one new write per cycle per port.
REQ-020 SHALL read the array at the sampling edge N of a read and present data on o_dout_x with o_valid_x=1 in the cycle following edge N+READ_LATENCY_X-1.
REQ-021 SHALL be read-first: a read sampled at the edge a write commits to the same address returns pre-write data; pending uncommitted writes are not forwarded.
REQ-022 SHALL, when both ports commit to the same address at the same edge, apply port A's enabled bytes over port B's (A wins per byte; B-only bytes keep B's data).
REQ-023 SHALL hold o_dout_x at its last valid value while o_valid_x=0.
REQ-024 SHALL allow one read per cycle per port fully pipelined; back-to-back reads yield back-to-back o_valid_x pulses in issue order.

Reset
REQ-025 SHALL, at an edge with i_rst=1, clear all read/write pipeline stages, drive o_dout_a/b=0, o_valid_a/b=0, o_wr_collision=0.
REQ-026 SHALL discard in-flight writes and reads on reset mid-operation; no array commit occurs at or after the reset edge for requests sampled before it.
REQ-027 SHALL ignore requests sampled while i_rst=1 and leave array contents unchanged by reset.

Configuration
REQ-028 SHALL, with macro DPRAM_COLLISION_DETECT_EN defined, pulse o_wr_collision high for the one cycle after any edge where both ports commit to the same address with overlapping byte enables.
REQ-029 SHALL, without DPRAM_COLLISION_DETECT_EN, tie o_wr_collision to 0 and omit the detection logic; REQ-022 priority still applies.

Verification
REQ-030 SHALL cover: A writes 0xA5A5 to addr 3, be=2'b11, at edge 0; B reads addr 3 at edge 2 (commit edge) -> old data; B reads at edge 3 -> o_valid_b after edge 5 with 0xA5A5.
REQ-031 SHALL cover: A reads addrs 0,1,2 on consecutive edges after 0x1111/0x2222/0x3333 are stored -> o_valid_a high 3 consecutive cycles with data in order, latency 2.
REQ-032 SHALL cover: A writes 0xAAAA be=2'b01 at edge 0, B writes 0xBBBB be=2'b11 at edge 1, both to addr 7 (both commit at edge 2) -> addr 7 = 0xBBAA; o_wr_collision=1 one cycle only if macro defined.
REQ-033 SHALL cover: A write to addr 5 at edge 0, i_rst=1 at edge 1 -> addr 5 unchanged, o_valid_a/b=0, o_dout_a/b=0.
REQ-034 SHALL cover: write with be=0 to addr 9 holding 0x1234 -> read returns 0x1234, o_wr_collision stays 0.
REQ-035 SHALL cover: i_en_b=0 with i_we_b=1 and valid addr/data -> no array change and no o_valid_b pulse.
